// File: rtl/prefix_logic_pipe_pkg.sv
// Shared definitions for the prefix logic pipeline: op encodings and the
// single-bit combine step used by the prefix chain.
package prefix_logic_pipe_pkg;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_NAND = 2'b11;

  // NAND runs the AND chain; the inversion is applied to the finished prefix.
  function automatic logic combine(input logic [1:0] op, input logic acc, input logic b);
    logic r;
    case (op)
      OP_OR:   r = acc | b;
      OP_XOR:  r = acc ^ b;
      default: r = acc & b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/prefix_logic_comb.sv
// Purely combinational prefix reduction: prefix[k] = data[0] op ... op data[k+1].
module prefix_logic_comb
  import prefix_logic_pipe_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] data,
  input  logic [1:0]       op,
  output logic [WIDTH-2:0] prefix
);

  logic [WIDTH-2:0] chain;

  always_comb begin
    logic acc;
    chain = '0;
    acc   = data[0];
    for (int k = 0; k < WIDTH - 1; k++) begin
      acc      = combine(op, acc, data[k+1]);
      chain[k] = acc;
    end
    prefix = (op == OP_NAND) ? ~chain : chain;
  end

endmodule

// File: rtl/prefix_logic_pipe.sv
// Prefix logic reduction feeding a DEPTH-stage valid/ready pipeline with
// back-pressure and a saturating count of completed output handshakes.
module prefix_logic_pipe
  import prefix_logic_pipe_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-2:0] out_prefix,
  output logic             out_all,
  output logic [CNT_W-1:0] txn_cnt,
  output logic             busy
);

  // Handshake: a beat moves across any boundary on a clk edge where the
  // sender's valid and the receiver's ready are both high; a sender holds
  // its beat stable until that edge.

  logic [WIDTH-2:0] in_prefix;
  logic [DEPTH-1:0] stg_valid;

  prefix_logic_comb #(.WIDTH(WIDTH)) u_comb (
    .data   (in_data),
    .op     (in_op),
    .prefix (in_prefix)
  );

  for (genvar i = 0; i < DEPTH; i++) begin : stg
    logic             valid_d, valid_q;
    logic [WIDTH-2:0] prefix_d, prefix_q;
    logic             src_valid, next_load, load;
    logic [WIDTH-2:0] src_prefix;

    if (i == 0) begin : g_src
      assign src_valid  = in_valid;
      assign src_prefix = in_prefix;
    end else begin : g_src
      assign src_valid  = stg[i-1].valid_q;
      assign src_prefix = stg[i-1].prefix_q;
    end

    if (i == DEPTH - 1) begin : g_nxt
      assign next_load = out_ready;
    end else begin : g_nxt
      assign next_load = stg[i+1].load;
    end

    // A stage reloads when it is empty or its current beat moves on.
    assign load = ~valid_q | next_load;

    always_comb begin
      valid_d  = valid_q;
      prefix_d = prefix_q;
      if (load) begin
        valid_d = src_valid;
        if (src_valid) prefix_d = src_prefix;
      end
    end

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        valid_q  <= 1'b0;
        prefix_q <= '0;
      end else begin
        valid_q  <= valid_d;
        prefix_q <= prefix_d;
      end
    end

    assign stg_valid[i] = valid_q;
  end

  assign in_ready   = stg[0].load;
  assign out_valid  = stg[DEPTH-1].valid_q;
  assign out_prefix = stg[DEPTH-1].prefix_q;
  assign out_all    = out_prefix[WIDTH-2];
  assign busy       = |stg_valid;

  logic [CNT_W-1:0] txn_cnt_d, txn_cnt_q;

  always_comb begin
    txn_cnt_d = txn_cnt_q;
    if (out_valid && out_ready && (txn_cnt_q != {CNT_W{1'b1}}))
      txn_cnt_d = txn_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) txn_cnt_q <= '0;
    else          txn_cnt_q <= txn_cnt_d;
  end

  assign txn_cnt = txn_cnt_q;

endmodule

// File: tb/tb_prefix_logic_pipe.sv
// Directed bench for prefix_logic_pipe: expected prefixes are queued when a
// beat is accepted and a negedge monitor pops and compares each output beat.
module tb_prefix_logic_pipe;

  localparam logic [1:0] AND_OP  = 2'b00;
  localparam logic [1:0] OR_OP   = 2'b01;
  localparam logic [1:0] XOR_OP  = 2'b10;
  localparam logic [1:0] NAND_OP = 2'b11;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // main instance: WIDTH=3, DEPTH=2, CNT_W=8
  logic       in_valid = 1'b0, in_ready;
  logic [2:0] in_data = '0;
  logic [1:0] in_op = '0;
  logic       out_valid, out_ready = 1'b1, out_all, busy;
  logic [1:0] out_prefix;
  logic [7:0] txn_cnt;

  // counter instance: CNT_W=2
  logic       c_in_valid = 1'b0, c_in_ready;
  logic [2:0] c_in_data = '0;
  logic [1:0] c_in_op = '0;
  logic       c_out_valid, c_out_ready = 1'b1, c_out_all, c_busy;
  logic [1:0] c_out_prefix;
  logic [1:0] c_txn_cnt;

  prefix_logic_pipe #(.WIDTH(3), .DEPTH(2), .CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready), .out_prefix(out_prefix),
    .out_all(out_all), .txn_cnt(txn_cnt), .busy(busy)
  );

  prefix_logic_pipe #(.WIDTH(3), .DEPTH(2), .CNT_W(2)) dut_cnt (
    .clk(clk), .reset_n(reset_n),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data), .in_op(c_in_op),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_prefix(c_out_prefix),
    .out_all(c_out_all), .txn_cnt(c_txn_cnt), .busy(c_busy)
  );

  // ---------------- scoreboard ----------------
  logic [1:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  logic       held_v = 1'b0;
  logic [1:0] held_p = '0;

  always @(negedge clk) begin
    logic [1:0] e;
    if (!reset_n) begin
      held_v = 1'b0;
    end else begin
      if (held_v && out_valid) check("hold_prefix", out_prefix, held_p);
      if (out_valid && out_ready) begin
        check("beat_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("out_prefix", out_prefix, e);
          check("out_all", out_all, e[1]);
        end
      end
      held_v = out_valid && !out_ready;
      held_p = out_prefix;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_beat(input logic [2:0] d, input logic [1:0] op,
                           input logic [1:0] exp, input bit push, output int waited);
    in_data  = d;
    in_op    = op;
    in_valid = 1'b1;
    waited   = 0;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      check("accept_timeout", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      return;
    end
    if (push) exp_q.push_back(exp);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int cyc = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || busy) && cyc < 50) begin
      cyc++;
      @(negedge clk);
    end
    check("drain_timeout", (exp_q.size() != 0) || busy, 0);
    @(posedge clk); #1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int w;
    int lat;
    int cyc;
    int exp_cnt;

    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // reset state
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_prefix", out_prefix, 0);
    check("rst_out_all", out_all, 0);
    check("rst_txn_cnt", txn_cnt, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_c_txn_cnt", c_txn_cnt, 0);
    @(posedge clk); #1;

    // single AND beat: latency and count
    send_beat(3'b011, AND_OP, 2'b01, 1'b1, w);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 20);
    check("latency", lat, 2);
    @(negedge clk);
    check("txn_cnt_single", txn_cnt, 1);
    @(posedge clk); #1;

    // back-to-back beats, one per cycle
    send_beat(3'b111, AND_OP,  2'b11, 1'b1, w); check("b2b_wait0", w, 0);
    send_beat(3'b100, OR_OP,   2'b10, 1'b1, w); check("b2b_wait1", w, 0);
    send_beat(3'b111, XOR_OP,  2'b10, 1'b1, w); check("b2b_wait2", w, 0);
    send_beat(3'b111, NAND_OP, 2'b00, 1'b1, w); check("b2b_wait3", w, 0);
    wait_drain();
    check("txn_cnt_b2b", txn_cnt, 5);

    // back-pressure: capacity is two beats, third held
    out_ready = 1'b0;
    send_beat(3'b111, AND_OP, 2'b11, 1'b1, w); check("bp_wait0", w, 0);
    send_beat(3'b011, AND_OP, 2'b01, 1'b1, w); check("bp_wait1", w, 0);
    in_data  = 3'b001;
    in_op    = AND_OP;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
      check("bp_stall_prefix", out_prefix, 2'b11);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send_beat(3'b001, AND_OP, 2'b00, 1'b1, w); check("bp_release_wait", w, 0);
    wait_drain();

    // full pipeline: accept and emit in the same cycle
    out_ready = 1'b0;
    send_beat(3'b001, OR_OP,  2'b11, 1'b1, w);
    send_beat(3'b011, XOR_OP, 2'b00, 1'b1, w);
    @(negedge clk);
    check("full_in_ready", in_ready, 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send_beat(3'b001, XOR_OP, 2'b11, 1'b1, w); check("simul_wait", w, 0);
    @(negedge clk);
    check("simul_busy", busy, 1);
    check("simul_out_valid", out_valid, 1);
    wait_drain();

    // reset with two beats in flight
    out_ready = 1'b0;
    send_beat(3'b111, AND_OP, 2'b11, 1'b0, w);
    send_beat(3'b111, OR_OP,  2'b11, 1'b0, w);
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_txn_cnt", txn_cnt, 0);
    check("mid_rst_out_prefix", out_prefix, 0);
    check("mid_rst_in_ready", in_ready, 1);
    repeat (5) @(negedge clk);
    check("mid_rst_no_stale", out_valid, 0);
    @(posedge clk); #1;

    // saturating counter on the CNT_W=2 instance
    for (int k = 1; k <= 5; k++) begin
      c_in_data  = 3'b101;
      c_in_op    = OR_OP;
      c_in_valid = 1'b1;
      @(negedge clk);
      check("c_in_ready", c_in_ready, 1);
      @(posedge clk); #1;
      c_in_valid = 1'b0;
      cyc = 0;
      @(negedge clk);
      while (!c_out_valid && cyc < 20) begin
        cyc++;
        @(negedge clk);
      end
      check("c_out_valid", c_out_valid, 1);
      check("c_out_prefix", c_out_prefix, 2'b11);
      @(negedge clk);
      exp_cnt = (k > 3) ? 3 : k;
      check("c_txn_cnt", c_txn_cnt, exp_cnt);
      @(posedge clk); #1;
    end

    check("exp_q_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
